// File: rtl/branch_predictor_pkg.sv
// Shared definitions for the fetch-side branch direction predictor.
//   - 2-bit saturating counter encodings (SN/WN/WT/ST)
//   - default table index width
package branch_predictor_pkg;

  localparam int BP_IDX_W = 6;

  typedef logic [1:0] bp_ctr_t;

  localparam bp_ctr_t BP_SN = 2'b00;
  localparam bp_ctr_t BP_WN = 2'b01;
  localparam bp_ctr_t BP_WT = 2'b10;
  localparam bp_ctr_t BP_ST = 2'b11;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// bp_sat_counter2: combinational next-state function of a 2-bit saturating
// direction counter.
// Ports:
//   cur   in  2 : current counter value
//   taken in  1 : resolved branch direction
//   nxt   out 2 : counter value after training with this outcome
module bp_sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       taken,
  output logic [1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (taken) begin
      if (cur != BP_ST) nxt = cur + 2'd1;
    end else begin
      if (cur != BP_SN) nxt = cur - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit dynamic branch direction predictor for fetch.
// A table of 2^IDX_W saturating counters, indexed by pc[IDX_W+1:2] with no
// tag, is looked up by fetch and trained by the decode-stage resolution.
// Ports:
//   clk         in  1  : clock, rising edge
//   resetn      in  1  : asynchronous active-low reset
//   pred_valid  in  1  : fetch lookup request
//   pred_pc     in  32 : fetch PC
//   stall       in  1  : hold the registered prediction
//   flush       in  1  : clear the registered prediction (beats stall)
//   pred_taken  out 1  : registered prediction for the instruction in decode
//   upd_valid   in  1  : branch resolved this cycle
//   upd_pc      in  32 : PC of the resolved branch
//   upd_taken   in  1  : resolved direction
//   upd_pred    in  1  : prediction that was used for it
//   mispredict  out 1  : one-cycle pulse after a mispredicted update
//   branch_cnt  out 32 : resolved branch count (wraps)
//   miss_cnt    out 32 : mispredicted branch count (wraps)
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int IDX_W = BP_IDX_W
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pred_valid,
  input  logic [31:0] pred_pc,
  input  logic        stall,
  input  logic        flush,
  output logic        pred_taken,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic        upd_pred,
  output logic        mispredict,
  output logic [31:0] branch_cnt,
  output logic [31:0] miss_cnt
);

  localparam int NENT = 1 << IDX_W;

  // Flop array rather than RAM: every entry needs a reset value.
  bp_ctr_t ctr_tbl [NENT];

  logic [IDX_W-1:0] pred_idx_p0;
  logic [IDX_W-1:0] upd_idx_p0;
  bp_ctr_t          upd_cur_p0;
  bp_ctr_t          upd_nxt_p0;
  logic             miss_p0;
  logic             pred_taken_p1;

  assign pred_idx_p0 = pred_pc[IDX_W+1:2];
  assign upd_idx_p0  = upd_pc[IDX_W+1:2];
  assign upd_cur_p0  = ctr_tbl[upd_idx_p0];
  assign miss_p0     = upd_valid && (upd_taken != upd_pred);

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pred_pc[31:IDX_W+2], pred_pc[1:0],
                            upd_pc[31:IDX_W+2], upd_pc[1:0]};

  bp_sat_counter2 u_sat (
    .cur   (upd_cur_p0),
    .taken (upd_taken),
    .nxt   (upd_nxt_p0)
  );

  // ---- p0 -> p1: table training, registered lookup, monitor counters ----
  // The lookup reads the table before this edge's write lands, so a
  // same-cycle lookup/update on one index sees the old counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NENT; i++) ctr_tbl[i] <= BP_WN;
    end else if (upd_valid) begin
      ctr_tbl[upd_idx_p0] <= upd_nxt_p0;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pred_taken_p1 <= 1'b0;
    end else if (flush) begin
      pred_taken_p1 <= 1'b0;
    end else if (!stall) begin
      pred_taken_p1 <= pred_valid && ctr_tbl[pred_idx_p0][1];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mispredict <= 1'b0;
      branch_cnt <= 32'd0;
      miss_cnt   <= 32'd0;
    end else begin
      mispredict <= miss_p0;
      if (upd_valid) branch_cnt <= branch_cnt + 32'd1;
      if (miss_p0)   miss_cnt   <= miss_cnt + 32'd1;
    end
  end

  assign pred_taken = pred_taken_p1;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        resetn;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        stall;
  logic        flush;
  logic        pred_taken;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        upd_pred;
  logic        mispredict;
  logic [31:0] branch_cnt;
  logic [31:0] miss_cnt;

  int checks = 0;
  int errors = 0;

  branch_predictor #(.IDX_W(6)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .pred_valid (pred_valid),
    .pred_pc    (pred_pc),
    .stall      (stall),
    .flush      (flush),
    .pred_taken (pred_taken),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_pred   (upd_pred),
    .mispredict (mispredict),
    .branch_cnt (branch_cnt),
    .miss_cnt   (miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one rising edge, then back to the falling edge where inputs change and outputs are sampled
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    pred_valid = 0; stall = 0; flush = 0; upd_valid = 0;
  endtask

  task automatic upd(input logic [31:0] pc, input logic t, input logic p);
    upd_valid = 1; upd_pc = pc; upd_taken = t; upd_pred = p;
  endtask

  task automatic look(input logic [31:0] pc);
    pred_valid = 1; pred_pc = pc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    resetn = 1; pred_pc = 0; upd_pc = 0; upd_taken = 0; upd_pred = 0;
    idle();
    #2 resetn = 0;

    // Reset with a lookup pending
    look(32'h0040_0000);
    cyc(); cyc();
    chk("rst_pred", {31'd0, pred_taken}, 0);
    chk("rst_misp", {31'd0, mispredict}, 0);
    chk("rst_bcnt", branch_cnt, 0);
    chk("rst_mcnt", miss_cnt, 0);
    resetn = 1;
    cyc();
    chk("first_lookup_wn", {31'd0, pred_taken}, 0);

    // Train idx 4 taken twice -> ST
    idle(); upd(32'h0040_0010, 1, 1); cyc();
    upd(32'h0040_0010, 1, 1); cyc();
    idle(); look(32'h0040_0010); cyc();
    chk("trained_taken", {31'd0, pred_taken}, 1);
    idle(); cyc();
    chk("no_req_zero", {31'd0, pred_taken}, 0);
    // third taken saturates; one not-taken leaves WT, second leaves WN
    upd(32'h0040_0010, 1, 1); cyc();
    upd(32'h0040_0010, 0, 0); cyc();
    idle(); look(32'h0040_0010); cyc();
    chk("st_saturated", {31'd0, pred_taken}, 1);
    idle(); upd(32'h0040_0010, 0, 0); cyc();
    idle(); look(32'h0040_0010); cyc();
    chk("back_to_wn", {31'd0, pred_taken}, 0);
    chk("train_bcnt", branch_cnt, 5);
    chk("train_mcnt", miss_cnt, 0);
    chk("train_misp", {31'd0, mispredict}, 0);

    // Mispredict pulse
    idle(); upd(32'h0040_0030, 1, 0); cyc();
    chk("misp_pulse", {31'd0, mispredict}, 1);
    upd(32'h0040_0030, 0, 0); cyc();
    chk("misp_clear", {31'd0, mispredict}, 0);
    idle(); cyc();
    chk("misp_idle", {31'd0, mispredict}, 0);
    chk("misp_bcnt", branch_cnt, 7);
    chk("misp_mcnt", miss_cnt, 1);

    // Same-cycle lookup and update on idx 8 (WN): read-before-write
    look(32'h0040_0020); upd(32'h0040_0020, 1, 0); cyc();
    chk("collide_old", {31'd0, pred_taken}, 0);
    chk("collide_misp", {31'd0, mispredict}, 1);
    upd_valid = 0; cyc();
    chk("collide_new", {31'd0, pred_taken}, 1);

    // Stall holds, flush overrides stall
    look(32'h0040_0000); stall = 1;
    cyc(); chk("stall_1", {31'd0, pred_taken}, 1);
    cyc(); chk("stall_2", {31'd0, pred_taken}, 1);
    cyc(); chk("stall_3", {31'd0, pred_taken}, 1);
    flush = 1; cyc();
    chk("flush_over_stall", {31'd0, pred_taken}, 0);
    stall = 0; flush = 0; look(32'h0040_0020); cyc();
    chk("after_flush", {31'd0, pred_taken}, 1);
    // flush beats a valid lookup; update still trains idx 16 during flush
    flush = 1; upd(32'h0040_0040, 1, 1); cyc();
    chk("flush_lookup", {31'd0, pred_taken}, 0);
    idle(); look(32'h0040_0040); cyc();
    chk("upd_during_flush", {31'd0, pred_taken}, 1);
    chk("flush_bcnt", branch_cnt, 9);
    chk("flush_mcnt", miss_cnt, 2);

    // Aliasing: 0x00400100 shares idx 0 with 0x00400000
    idle(); upd(32'h0040_0000, 1, 1); cyc();
    idle(); look(32'h0040_0100); cyc();
    chk("alias", {31'd0, pred_taken}, 1);

    // branch_cnt wrap
    idle();
    force dut.branch_cnt = 32'hFFFF_FFFF;
    #1 release dut.branch_cnt;
    upd(32'h0040_0080, 0, 0); cyc();
    chk("bcnt_wrap", branch_cnt, 0);
    chk("wrap_mcnt", miss_cnt, 2);

    // Asynchronous reset mid-operation discards the pending update
    idle(); upd(32'h0040_0020, 1, 1); look(32'h0040_0020);
    #2 resetn = 0;
    #1;
    chk("async_pred", {31'd0, pred_taken}, 0);
    chk("async_bcnt", branch_cnt, 0);
    chk("async_mcnt", miss_cnt, 0);
    @(negedge clk);
    idle(); resetn = 1; look(32'h0040_0020); cyc();
    chk("reset_table_wn", {31'd0, pred_taken}, 0);
    chk("reset_bcnt_hold", branch_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-side 2-bit dynamic branch direction predictor for the MIPS pipeline. Fetch performs a lookup on each fetch PC. The decode-stage branch comparator returns the resolved outcome through the update port, which trains the table. The block reports mispredictions and counts branches and misses for performance monitoring.

## Interface
Parameters:
- `IDX_W`, default 6: table index width; the table has 2^IDX_W entries, indexed by `pc[IDX_W+1:2]`.

Ports:
- `clk` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `pred_valid` in 1: fetch lookup request this cycle.
- `pred_pc` in 32: fetch PC.
- `stall` in 1: decode stalled; hold the registered prediction.
- `flush` in 1: pipeline flush; clear the registered prediction.
- `pred_taken` out 1: registered prediction for the instruction now in decode.
- `upd_valid` in 1: a branch was resolved in decode this cycle.
- `upd_pc` in 32: PC of the resolved branch.
- `upd_taken` in 1: resolved direction (comparator output).
- `upd_pred` in 1: prediction that was used for this branch.
- `mispredict` out 1: registered; pulses one cycle after an update whose `upd_taken != upd_pred`.
- `branch_cnt` out 32: number of resolved branches.
- `miss_cnt` out 32: number of mispredicted branches.

## Operation
- Table: 2^IDX_W 2-bit saturating counters.
  - Encodings: SN=2'b00, WN=2'b01, WT=2'b10, ST=2'b11.
  - Predict taken iff `counter[1]`.
- Lookup:
  - If `pred_valid && !stall && !flush`, `pred_taken` <= `table[pred_pc[IDX_W+1:2]][1]`.
  - If `!pred_valid && !stall && !flush`, `pred_taken` <= 0.
  - If `stall && !flush`, `pred_taken` holds.
  - If `flush`, `pred_taken` <= 0. Flush has priority over stall.
- Update, when `upd_valid` at index `i = upd_pc[IDX_W+1:2]`:
  - If `upd_taken`, the counter increments and saturates at ST.
  - Otherwise it decrements and saturates at SN.
  - Updates are not blocked by `stall` or `flush`.
- Mispredict:
  - `mispredict` <= `upd_valid && (upd_taken != upd_pred)`, else 0.
  - It is a single-cycle pulse per update.
- Counters:
  - `branch_cnt` increments on every `upd_valid`.
  - `miss_cnt` increments when the mispredict condition holds.
  - Both wrap modulo 2^32 without saturating.
- Aliasing: PCs that share an index share a counter. There is no tag.

## Timing
- Reset (`resetn`=0, asynchronous):
  - Every table entry = WN.
  - `pred_taken`=0, `mispredict`=0, `branch_cnt`=0, `miss_cnt`=0.
  - Reset asserted mid-operation discards pending updates immediately.
- Lookup latency is 1 cycle: the request at edge N is visible on `pred_taken` after edge N+1.
- Update latency is 1 cycle: the counter write occurs at the same edge that registers `mispredict`.
- Same-cycle lookup and update to the same index is read-before-write: the lookup uses the old counter value, with no bypass.
- The first lookup after reset predicts not-taken (WN). A single taken update makes the next lookup of that index predict taken (WT).

## Structure
- Shared defines header: counter encodings `BP_SN`, `BP_WN`, `BP_WT`, `BP_ST`, and the `IDX_W` default.
- Sub-module `bp_sat_counter2`: purely combinational next-state function, (cur, taken) -> next.
  - `branch_predictor` instantiates one of these on the update path.
  - The table is a flop array with asynchronous reset, not inferred RAM, because it needs a reset value.

## Test plan
- **Reset:** hold `resetn`=0, lookup PC 0x00400000, release reset → `pred_taken`=0; counters = 0.
- **Train taken:** update PC 0x00400010 taken twice, then look it up → `pred_taken`=1; entry = ST; a third taken update leaves it at ST.
- **Mispredict count:** update with `upd_taken`=1 and `upd_pred`=0, then with `upd_taken`=0 and `upd_pred`=0 → `mispredict` pulses once, one cycle after the first update; `branch_cnt`=2, `miss_cnt`=1.
- **Same-cycle collision:** entry at WN; in one cycle, look up and update (taken) PC 0x00400020 → `pred_taken`=0; the next lookup returns 1.
- **Stall/flush:** `pred_taken`=1; assert `stall` for 3 cycles → it holds 1; then assert `stall`=1 and `flush`=1 together → `pred_taken`=0 the next cycle.
- **Aliasing and wrap:** with `IDX_W`=6, train PC 0x00400000 taken and look up 0x00400100 → `pred_taken`=1 (shared index). Force `branch_cnt` to 0xFFFFFFFF and apply one update → `branch_cnt`=0.
